// File: rtl/adc_stream_arbiter.sv
// Round-robin merge of per-channel averager result strobes onto one AXI-Stream master.
// Each channel has a one-deep holding register; unsent results are overwritten and flagged.
module adc_stream_arbiter #(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [CH_NUM-1:0]        i_ch_en,
  input  logic [CH_NUM*DATA_W-1:0] adc_s_axis_tdata,
  input  logic [CH_NUM-1:0]        adc_s_axis_tvalid,
  output logic [DATA_W-1:0]        adc_m_axis_tdata,
  output logic [2:0]               adc_m_axis_tdest,
  output logic                     adc_m_axis_tvalid,
  input  logic                     adc_m_axis_tready,
  input  logic                     i_ovr_clr,
  output logic [CH_NUM-1:0]        o_ovr
);

  localparam int IDX_W = $clog2(CH_NUM);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [DATA_W-1:0] hold [CH_NUM];
  logic [CH_NUM-1:0] pend;
  logic [IDX_W-1:0]  last_grant;

  logic [CH_NUM-1:0] cand;
  logic [CH_NUM-1:0] capture;
  logic [CH_NUM-1:0] grant_oh;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant;
  int                best_off;
  int                off;

  assign cand    = pend & i_ch_en;
  assign capture = adc_s_axis_tvalid & i_ch_en;

  // Pick the candidate with the smallest rotational distance past last_grant.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    best_off  = CH_NUM;
    off       = 0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      off = (k + CH_NUM - 1 - int'(last_grant)) % CH_NUM;
      if (cand[k] && off < best_off) begin
        best_off  = off;
        grant_idx = IDX_W'(k);
      end
    end
    grant = (state == IDLE) && (best_off < CH_NUM);
    for (int k = 0; k < CH_NUM; k++) begin
      grant_oh[k] = grant && (grant_idx == IDX_W'(k));
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    if (i_rst) begin
      state             <= IDLE;
      adc_m_axis_tvalid <= 1'b0;
      adc_m_axis_tdata  <= '0;
      adc_m_axis_tdest  <= '0;
      pend              <= '0;
      o_ovr             <= '0;
      last_grant        <= IDX_W'(CH_NUM - 1);
      // NOTE: the holding registers are flops, not a RAM, so clearing them on reset is cheap and defined.
      for (int k = 0; k < CH_NUM; k++) begin
        hold[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (!i_ch_en[k]) begin
          pend[k] <= 1'b0;
        end else if (capture[k]) begin
          pend[k] <= 1'b1;
          hold[k] <= adc_s_axis_tdata[k*DATA_W +: DATA_W];
        end else if (grant_oh[k]) begin
          pend[k] <= 1'b0;
        end
      end

      // A fresh overrun beats a simultaneous clear.
      o_ovr <= (i_ovr_clr ? '0 : o_ovr) | (capture & pend & ~grant_oh);

      case (state)
        IDLE: begin
          if (grant) begin
            state             <= SEND;
            adc_m_axis_tvalid <= 1'b1;
            adc_m_axis_tdata  <= hold[grant_idx];
            adc_m_axis_tdest  <= 3'(grant_idx);
            last_grant        <= grant_idx;
          end
        end
        SEND: begin
          if (adc_m_axis_tvalid && adc_m_axis_tready) begin
            state             <= IDLE;
            adc_m_axis_tvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/adc_stream_arbiter.md
# adc_stream_arbiter

Round-robin arbiter that merges the 32-bit averaged result streams of CH_NUM per-channel moving-sum averagers onto one AXI-Stream master toward the shared floating-point converter. Each channel gets a one-deep holding register, so a single-cycle result pulse is never lost while another channel owns the output. A newer result overwrites an unsent one and raises a sticky per-channel overrun flag. The output carries the source channel index on tdest.

## Interface
- CH_NUM, 4: number of averager channels, legal range 2..8.
- DATA_W, 32: result width per channel.
- i_clk  in  1  single clock for all logic.
- i_rst  in  1  reset, synchronous, active-high.
- i_ch_en  in  CH_NUM  per-channel enable; bit k gates channel k.
- adc_s_axis_tdata  in  CH_NUM*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- adc_s_axis_tvalid  in  CH_NUM  one-cycle result strobe per channel; there is no ready signal.
- adc_m_axis_tdata  out  DATA_W  granted result.
- adc_m_axis_tdest  out  3  index of the granted channel.
- adc_m_axis_tvalid  out  1  output valid.
- adc_m_axis_tready  in  1  downstream ready.
- i_ovr_clr  in  1  clears all overrun flags.
- o_ovr  out  CH_NUM  sticky overrun flags.

## Operation
- Per-channel state: hold[k] (DATA_W bits) and pend[k].
- Capture rule. When adc_s_axis_tvalid[k] and i_ch_en[k] are both high at an edge:
  - hold[k] loads the slice.
  - pend[k] is set.
- Overrun rule. A capture sets o_ovr[k] if pend[k] was already 1 and channel k is not granted at that same edge.
- Disable rule. When i_ch_en[k] is low, captures on k are ignored and pend[k] clears at the next edge. o_ovr[k] is kept.
- Overrun clear. i_ovr_clr clears every o_ovr bit. An overrun set at the same edge wins.
- FSM has two states, IDLE and SEND.
  - IDLE: if any pend[k]&i_ch_en[k] is set, grant the first such k searching upward from last_grant+1, wrapping modulo CH_NUM.
  - On a grant, load adc_m_axis_tdata=hold[k] and tdest=k, clear pend[k], set last_grant=k, and go to SEND.
  - If a capture on k happens at the grant edge, pend[k] stays 1 holding the new sample. The output gets the old hold value. No overrun is flagged.
  - SEND: tvalid=1. tdata and tdest stay stable until adc_m_axis_tvalid&adc_m_axis_tready; on that handshake edge, go to IDLE.
  - Once granted, a result is always delivered, even if i_ch_en[k] drops during SEND.
- Captures into hold continue in every state; the output register is separate from the holding registers.
- The block performs no arithmetic on the data; tdata is passed through bit-exact.

## Timing
- Reset values, applied at the first edge with i_rst=1:
  - state=IDLE, tvalid=0, tdata=0, tdest=0.
  - pend=0, hold=0, o_ovr=0.
  - last_grant=CH_NUM-1, so channel 0 has first priority.
- Reset in SEND drops tvalid at the next edge and discards the in-flight result.
- Latency: a strobe captured at edge t is granted at edge t+1, and tvalid is high from t+1.
- Throughput: one result per 2 cycles minimum (SEND followed by IDLE), with tready held high.
- Backpressure: while tready=0, the FSM stays in SEND and the other channels accumulate in hold/pend.
- Fairness: a channel with pend set waits at most CH_NUM-1 other grants before its own.
- o_ovr updates at the edge of the overwriting capture and is visible on the next cycle.

## Test plan
- Single result:
  - Stimulus: CH_NUM=4, all enabled, tready=1; channel 2 strobes 0x0012_3456 at edge t.
  - Required: tvalid high during cycle t+1..t+2 with tdata=0x0012_3456, tdest=2; tvalid low after the handshake edge; o_ovr=0.
- Simultaneous strobes:
  - Stimulus: all 4 channels strobe values 0xA0..0xA3 at the same edge; tready=1.
  - Required: outputs in order tdest 0,1,2,3, with tvalid asserted every other cycle and data matching each channel.
- Backpressure with overrun:
  - Stimulus: tready=0; channel 1 strobes 0x11 and is granted; channel 3 strobes 0x33, then 0x34 two cycles later; then tready=1.
  - Required: tdata stays 0x11 through the stall; next output is 0x34 with tdest=3; o_ovr=4'b1000.
  - Then, with i_ovr_clr asserted in the same cycle as a fresh overrun on channel 0, the next o_ovr is 4'b0001.
- Capture at the grant edge:
  - Stimulus: channel 0 strobes 0x50; its next strobe 0x51 lands exactly at the grant edge.
  - Required: outputs 0x50 then 0x51, both tdest=0, with no overrun.
- Round-robin fairness:
  - Stimulus: channels 0 and 3 re-strobe continuously while channel 1 strobes once; tready=1.
  - Required: channel 1 is delivered within 3 grants.
- Enable and reset:
  - Stimulus: clear i_ch_en[2] while pend[2]=1.
  - Required: channel 2 is never output, and later strobes on channel 2 are ignored.
  - Stimulus: assert i_rst during SEND.
  - Required: tvalid=0 and pend=0 on the next cycle, and the first post-reset grant goes to the lowest pending channel.
